sdreq_chan_ctrl: RTL and testbench

// - Snoop-bus downstream request channel controller for the L1/L2 cache controller.
// - Accepts one internal request (SDREQ_RD/RFO/INV/WB) from the cache FSM when it is in *_INIT_SDREQ.
// - Drives that request onto the sdreq channel with a 4-phase valid/ready handshake.
// - Collects the matching sursp response with a 4-phase handshake and returns it to the FSM in *_WAIT_SURSP.
// - One outstanding transaction; timeout guard on the response.

---
 rtl/cache_pkg.sv | 42 ++++
 rtl/hs4_ctrl.sv | 55 +++++
 rtl/sdreq_chan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sdreq_chan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-controller encodings: snoop-bus request/response codes, 4-phase
// handshake states and the sdreq channel top-FSM states.
package cache_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned HS_W   = 2;
    localparam int unsigned SDCH_W = 2;

    localparam logic [OP_W-1:0] SDREQ_RD  = 3'd0;
    localparam logic [OP_W-1:0] SDREQ_RFO = 3'd1;
    localparam logic [OP_W-1:0] SDREQ_INV = 3'd2;
    localparam logic [OP_W-1:0] SDREQ_WB  = 3'd3;

    localparam logic [OP_W-1:0] SURSP_OKAY  = 3'd0;
    localparam logic [OP_W-1:0] SURSP_FETCH = 3'd1;
    localparam logic [OP_W-1:0] SURSP_SNOOP = 3'd2;
    localparam logic [OP_W-1:0] SURSP_ERROR = 3'd3;

    localparam logic [HS_W-1:0] HS_IDLE     = 2'd0;
    localparam logic [HS_W-1:0] HS_ASSERT   = 2'd1;
    localparam logic [HS_W-1:0] HS_DEASSERT = 2'd2;

    localparam logic [SDCH_W-1:0] SDCH_IDLE     = 2'd0;
    localparam logic [SDCH_W-1:0] SDCH_SEND     = 2'd1;
    localparam logic [SDCH_W-1:0] SDCH_WAIT_RSP = 2'd2;
    localparam logic [SDCH_W-1:0] SDCH_RETURN   = 2'd3;

    function automatic logic sdreq_op_legal(input logic [OP_W-1:0] op);
        return op <= SDREQ_WB;
    endfunction

    // Writebacks only succeed on OKAY; unknown codes collapse to ERROR.
    function automatic logic [OP_W-1:0] sursp_map(input logic [OP_W-1:0] op,
                                                  input logic [OP_W-1:0] rsp);
        if (op == SDREQ_WB)
            return (rsp == SURSP_OKAY) ? SURSP_OKAY : SURSP_ERROR;
        if (rsp <= SURSP_ERROR)
            return rsp;
        return SURSP_ERROR;
    endfunction

endpackage

// File: rtl/hs4_ctrl.sv
// Generic 4-phase handshake FSM. Initiator drives valid and watches ready;
// responder drives ready and watches valid.
module hs4_ctrl
    import cache_pkg::*;
#(
    parameter bit INITIATOR = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic peer,
    output logic drive,
    output logic idle_c,
    output logic done_c
);

    logic [HS_W-1:0] state_q;
    logic [HS_W-1:0] state_d;

    // Initiator starts on en alone; responder needs the peer's valid as well.
    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (en && (INITIATOR || peer))
                    state_d = HS_ASSERT;
            end
            HS_ASSERT: begin
                if (peer == INITIATOR)
                    state_d = HS_DEASSERT;
            end
            HS_DEASSERT: begin
                if (!INITIATOR || !peer) begin
                    state_d = HS_IDLE;
                    done_c  = 1'b1;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            drive   <= 1'b0;
        end else begin
            state_q <= state_d;
            drive   <= (state_d == HS_ASSERT);
        end
    end

    assign idle_c = (state_q == HS_IDLE);

endmodule

// File: rtl/sdreq_chan_ctrl.sv
// Snoop-bus downstream request channel: one FSM request out over a 4-phase sdreq
// handshake, one sursp response back, with a response timeout.
module sdreq_chan_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_code,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sdreq_valid,
    input  logic                  sdreq_ready,
    output logic [2:0]            sdreq_op,
    output logic [ADDR_WIDTH-1:0] sdreq_addr,
    output logic [DATA_WIDTH-1:0] sdreq_data,
    input  logic                  sursp_valid,
    output logic                  sursp_ready,
    input  logic [2:0]            sursp_rsp,
    input  logic [DATA_WIDTH-1:0] sursp_data
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam bit               TMR_EN   = (TIMEOUT_CYC != 0);

    logic [SDCH_W-1:0]     state_q;
    logic [SDCH_W-1:0]     state_d;
    logic [TMR_W-1:0]      timer_q;
    logic [TMR_W-1:0]      timer_d;
    logic [2:0]            op_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [2:0]            code_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    logic snd_idle_c;
    logic snd_done_c;
    logic rsp_idle_c;
    logic rsp_done_c;
    logic accept_c;
    logic snd_start_c;
    logic capture_c;
    logic expire_c;
    logic wait_rsp_c;

    // Only take a new request once both bus handshakes have fully returned to idle.
    assign accept_c    = (state_q == SDCH_IDLE) && req_valid && snd_idle_c && rsp_idle_c;
    assign snd_start_c = accept_c && sdreq_op_legal(req_op);
    assign wait_rsp_c  = (state_q == SDCH_WAIT_RSP);
    assign capture_c   = wait_rsp_c && rsp_idle_c && sursp_valid;
    assign expire_c    = TMR_EN && (timer_q == TMR_LAST);

    hs4_ctrl #(
        .INITIATOR (1'b1)
    ) u_sdreq_hs (
        .clk    (clk),
        .rst    (rst),
        .en     (snd_start_c),
        .peer   (sdreq_ready),
        .drive  (sdreq_valid),
        .idle_c (snd_idle_c),
        .done_c (snd_done_c)
    );

    hs4_ctrl #(
        .INITIATOR (1'b0)
    ) u_sursp_hs (
        .clk    (clk),
        .rst    (rst),
        .en     (wait_rsp_c),
        .peer   (sursp_valid),
        .drive  (sursp_ready),
        .idle_c (rsp_idle_c),
        .done_c (rsp_done_c)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        op_d    = sdreq_op;
        addr_d  = sdreq_addr;
        data_d  = sdreq_data;
        code_d  = rsp_code;
        rdata_d = rsp_data;
        case (state_q)
            SDCH_IDLE: begin
                timer_d = '0;
                if (accept_c) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    data_d = req_data;
                    if (sdreq_op_legal(req_op)) begin
                        state_d = SDCH_SEND;
                    end else begin
                        state_d = SDCH_RETURN;
                        code_d  = SURSP_ERROR;
                        rdata_d = '0;
                    end
                end
            end
            SDCH_SEND: begin
                if (snd_done_c)
                    state_d = SDCH_WAIT_RSP;
            end
            SDCH_WAIT_RSP: begin
                // A response seen in the expiry cycle takes priority over the timeout.
                if (capture_c) begin
                    code_d  = sursp_map(sdreq_op, sursp_rsp);
                    rdata_d = sursp_data;
                    timer_d = '0;
                end else if (rsp_idle_c) begin
                    if (expire_c) begin
                        code_d  = SURSP_ERROR;
                        rdata_d = '0;
                        timer_d = '0;
                        state_d = SDCH_RETURN;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                if (rsp_done_c)
                    state_d = SDCH_RETURN;
            end
            SDCH_RETURN: begin
                if (rsp_ready)
                    state_d = SDCH_IDLE;
            end
            default: state_d = SDCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SDCH_IDLE;
            timer_q    <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            sdreq_op   <= '0;
            sdreq_addr <= '0;
            sdreq_data <= '0;
            rsp_code   <= '0;
            rsp_data   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            req_ready  <= (state_d == SDCH_IDLE);
            rsp_valid  <= (state_d == SDCH_RETURN);
            sdreq_op   <= op_d;
            sdreq_addr <= addr_d;
            sdreq_data <= data_d;
            rsp_code   <= code_d;
            rsp_data   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sdreq_chan_ctrl.sv
// Directed bench for sdreq_chan_ctrl: bench plays FSM and bus agents, expected
// responses are queued at request time and checked when rsp_valid appears.
module tb_sdreq_chan_ctrl;
    import cache_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [2:0]    rsp_code;
    logic [DW-1:0] rsp_data;
    logic          sdreq_valid;
    logic          sdreq_ready;
    logic [2:0]    sdreq_op;
    logic [AW-1:0] sdreq_addr;
    logic [DW-1:0] sdreq_data;
    logic          sursp_valid;
    logic          sursp_ready;
    logic [2:0]    sursp_rsp;
    logic [DW-1:0] sursp_data;

    typedef struct packed {
        logic [2:0]    code;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sdreq_chan_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data),
        .sdreq_valid (sdreq_valid),
        .sdreq_ready (sdreq_ready),
        .sdreq_op    (sdreq_op),
        .sdreq_addr  (sdreq_addr),
        .sdreq_data  (sdreq_data),
        .sursp_valid (sursp_valid),
        .sursp_ready (sursp_ready),
        .sursp_rsp   (sursp_rsp),
        .sursp_data  (sursp_data)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] code, input logic [DW-1:0] data);
        rsp_t e;
        e.code = code;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready",   req_ready,   1'b1);
        chk("rst_rsp_valid",   rsp_valid,   1'b0);
        chk("rst_sdreq_valid", sdreq_valid, 1'b0);
        chk("rst_sursp_ready", sursp_ready, 1'b0);
        chk("rst_sdreq_pl",    {sdreq_op, sdreq_addr, sdreq_data}, 72'd0);
        chk("rst_rsp_pl",      {rsp_code, rsp_data}, 72'd0);
    endtask

    // Called on a negedge while idle; returns on the negedge after the accepting edge.
    task automatic send_req(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 1'b0);
    endtask

    // Bus agent for the sdreq side: ready rises 'delay' cycles after valid.
    task automatic bus_send(input logic [2:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int delay);
        logic [66:0] pl;
        pl = {op, addr, data};
        chk("sdreq_valid_rise", sdreq_valid, 1'b1);
        repeat (delay - 1) begin
            chk("sdreq_payload", {sdreq_op, sdreq_addr, sdreq_data}, pl);
            @(negedge clk);
            chk("sdreq_valid_hold", sdreq_valid, 1'b1);
        end
        chk("sdreq_payload", {sdreq_op, sdreq_addr, sdreq_data}, pl);
        sdreq_ready = 1'b1;
        @(negedge clk);
        chk("sdreq_valid_fall", sdreq_valid, 1'b0);
        chk("sdreq_payload_ack", {sdreq_op, sdreq_addr, sdreq_data}, pl);
        sdreq_ready = 1'b0;
        @(negedge clk);
        chk("sursp_ready_quiet", sursp_ready, 1'b0);
    endtask

    // Bus agent for the sursp side, starting on the first WAIT_RSP negedge.
    task automatic bus_rsp(input logic [2:0] code, input logic [DW-1:0] data, input int gap);
        repeat (gap) @(negedge clk);
        sursp_valid = 1'b1;
        sursp_rsp   = code;
        sursp_data  = data;
        @(negedge clk);
        chk("sursp_ready_rise", sursp_ready, 1'b1);
        chk("rsp_valid_early", rsp_valid, 1'b0);
        sursp_valid = 1'b0;
        @(negedge clk);
        chk("sursp_ready_fall", sursp_ready, 1'b0);
        chk("rsp_valid_lat1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("rsp_valid_lat2", rsp_valid, 1'b1);
    endtask

    // FSM side: holds rsp_ready low 'hold' cycles (optionally poking req_valid), then accepts.
    task automatic collect(input int hold, input bit poke);
        rsp_t e;
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (poke) begin
            req_valid = 1'b1;
            req_op    = SDREQ_RFO;
            req_addr  = 32'h9999_0000;
        end
        repeat (hold) begin
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_pl", {rsp_code, rsp_data}, e);
            chk("hold_req_ready", req_ready, 1'b0);
            chk("hold_sdreq_valid", sdreq_valid, 1'b0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_code", rsp_code, e.code);
        chk("rsp_data", rsp_data, e.data);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("req_ready_back", req_ready, 1'b1);
        if (poke) begin
            @(negedge clk);
            chk("no_second_accept", sdreq_valid, 1'b0);
            chk("no_second_ready", req_ready, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish by 100000ns, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = '0;
        req_addr    = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        sdreq_ready = 1'b0;
        sursp_valid = 1'b0;
        sursp_rsp   = '0;
        sursp_data  = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        // RD with slow bus ack and a FETCH fill
        push_exp(SURSP_FETCH, 32'hDEAD_BEEF);
        send_req(SDREQ_RD, 32'h40, 32'h0);
        bus_send(SDREQ_RD, 32'h40, 32'h0, 3);
        bus_rsp(SURSP_FETCH, 32'hDEAD_BEEF, 2);
        collect(0, 1'b0);

        // WB answered with SNOOP becomes ERROR
        push_exp(SURSP_ERROR, 32'h5555_0000);
        send_req(SDREQ_WB, 32'h80, 32'h1234);
        bus_send(SDREQ_WB, 32'h80, 32'h1234, 4);
        bus_rsp(SURSP_SNOOP, 32'h5555_0000, 1);
        collect(0, 1'b0);

        // WB with OKAY passes through
        push_exp(SURSP_OKAY, 32'h0000_0011);
        send_req(SDREQ_WB, 32'hC0, 32'hA5A5);
        bus_send(SDREQ_WB, 32'hC0, 32'hA5A5, 1);
        bus_rsp(SURSP_OKAY, 32'h0000_0011, 0);
        collect(0, 1'b0);

        // RFO forwards SNOOP unchanged
        push_exp(SURSP_SNOOP, 32'h0000_CAFE);
        send_req(SDREQ_RFO, 32'h100, 32'h0);
        bus_send(SDREQ_RFO, 32'h100, 32'h0, 1);
        bus_rsp(SURSP_SNOOP, 32'h0000_CAFE, 1);
        collect(0, 1'b0);

        // Illegal op: immediate ERROR, no bus activity
        push_exp(SURSP_ERROR, 32'h0);
        send_req(3'b101, 32'h140, 32'h99);
        chk("illegal_rsp_valid", rsp_valid, 1'b1);
        chk("illegal_no_sdreq", sdreq_valid, 1'b0);
        collect(2, 1'b0);
        chk("illegal_still_no_sdreq", sdreq_valid, 1'b0);

        // Timeout after TO cycles; late sursp_valid is not acknowledged
        push_exp(SURSP_ERROR, 32'h0);
        send_req(SDREQ_RD, 32'h200, 32'h0);
        bus_send(SDREQ_RD, 32'h200, 32'h0, 2);
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_cycles", cnt, TO);
        sursp_valid = 1'b1;
        sursp_rsp   = SURSP_FETCH;
        sursp_data  = 32'h1111_2222;
        repeat (2) begin
            @(negedge clk);
            chk("late_sursp_ignored", sursp_ready, 1'b0);
        end
        sursp_valid = 1'b0;
        collect(0, 1'b0);

        // Response in the expiry cycle wins over the timeout
        push_exp(SURSP_FETCH, 32'h0000_600D);
        send_req(SDREQ_RD, 32'h240, 32'h0);
        bus_send(SDREQ_RD, 32'h240, 32'h0, 1);
        bus_rsp(SURSP_FETCH, 32'h0000_600D, TO - 1);
        collect(0, 1'b0);

        // Back-pressured response with a competing request
        push_exp(SURSP_OKAY, 32'h0000_0077);
        send_req(SDREQ_INV, 32'h300, 32'h0);
        bus_send(SDREQ_INV, 32'h300, 32'h0, 2);
        bus_rsp(SURSP_OKAY, 32'h0000_0077, 3);
        collect(5, 1'b1);

        // Reset in the middle of SEND aborts silently
        send_req(SDREQ_RD, 32'h400, 32'h0);
        chk("abort_sdreq_valid", sdreq_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_rsp", rsp_valid, 1'b0);

        // Normal transaction after the abort
        push_exp(SURSP_OKAY, 32'h0000_0ABC);
        send_req(SDREQ_RFO, 32'h500, 32'h0);
        bus_send(SDREQ_RFO, 32'h500, 32'h0, 1);
        bus_rsp(SURSP_OKAY, 32'h0000_0ABC, 0);
        collect(0, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
